mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter_rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU constants and types for the memory arbiter.
// Holds the FSM encoding and default bus width.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int WORD_SIZE_DEF = 16;
    localparam int PORT_INSTR    = 0;
    localparam int PORT_DATA     = 1;
    localparam int MAX_PORTS     = 8;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]           req_read;
    logic [NUM_PORTS-1:0]           req_write;
    logic [NUM_PORTS*WORD_SIZE-1:0] req_address;
    logic [NUM_PORTS*WORD_SIZE-1:0] req_wdata;
    logic [WORD_SIZE-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]           req_done;
    logic                           req_err;
    logic                           mem_read;
    logic                           mem_write;
    logic [WORD_SIZE-1:0]           mem_address;
    logic [WORD_SIZE-1:0]           mem_wdata;
    logic [WORD_SIZE-1:0]           mem_rdata;
    logic                           mem_ready;

    modport master (
        input  req_read, req_write, req_address, req_wdata,
        input  mem_rdata, mem_ready,
        output req_rdata, req_done, req_err,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        output req_read, req_write, req_address, req_wdata,
        output mem_rdata, mem_ready,
        input  req_rdata, req_done, req_err,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational requester picker: fixed priority or
// round-robin search starting at i_start and wrapping.
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IW        = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IW-1:0]        i_start,
    input  logic                 i_rr,
    output logic [IW-1:0]        o_idx,
    output logic                 o_valid
);
    int w_base;
    int w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_base  = i_rr ? int'(i_start) : 0;
        w_cand  = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_cand = (w_base + k) % NUM_PORTS;
            if (i_req[w_cand]) begin
                o_idx   = IW'(w_cand);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NUM_PORTS requesters:
// one outstanding command, timeout abort, registered mem_* bus.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE   = 0,
    parameter int TIMEOUT   = 64
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.master bus
);
    localparam int             IW       = idx_w(NUM_PORTS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_PORTS - 1);
    localparam logic [7:0]     WAIT_MAX = 8'(TIMEOUT - 1);

    arb_state_e           r_state;
    arb_state_e           w_next;
    logic [IW-1:0]        r_grant;
    logic [IW-1:0]        w_start;
    logic [IW-1:0]        w_pick;
    logic                 w_valid;
    logic [7:0]           r_wait;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [WORD_SIZE-1:0] w_sel_addr;
    logic [WORD_SIZE-1:0] w_sel_wdata;
    logic                 w_sel_wr;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_done;
    logic                 w_err;
    logic                 w_timeout;
    logic [WORD_SIZE-1:0] w_rdata;

    assign w_req   = bus.req_read | bus.req_write;
    // r_grant doubles as last_grant for the round-robin start point.
    assign w_start = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .i_rr    (RR_MODE != 0),
        .o_idx   (w_pick),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_pick == IW'(i)) begin
                w_sel_addr  = bus.req_address[i*WORD_SIZE +: WORD_SIZE];
                w_sel_wdata = bus.req_wdata[i*WORD_SIZE +: WORD_SIZE];
                w_sel_wr    = bus.req_write[i];
            end
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && !bus.mem_ready &&
                       (r_wait == WAIT_MAX);

    always_comb begin
        w_next  = r_state;
        w_done  = '0;
        w_err   = 1'b0;
        w_rdata = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.mem_ready || w_timeout) begin
                    w_next = ST_IDLE;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (r_grant == IW'(i)) w_done[i] = 1'b1;
                    end
                    w_err   = w_timeout;
                    w_rdata = bus.mem_ready ? bus.mem_rdata : '0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // An aborted transaction must never report completion.
        if (reset) begin
            w_next  = ST_IDLE;
            w_done  = '0;
            w_err   = 1'b0;
            w_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= LAST_IDX;
            r_wait      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_pick;
                        r_wait      <= '0;
                        r_mem_write <= w_sel_wr;
                        r_mem_read  <= !w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                ST_BUSY: begin
                    if (w_next == ST_IDLE) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_done    = w_done;
    assign bus.req_err     = w_err;
    assign bus.req_rdata   = w_rdata;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;

endmodule
